// File: rtl/sequencer.sv
// Micro-state sequencer: fetch, decode and per-instruction step order.
// Optional single-step WAIT state behind SEQUENCER_SINGLE_STEP_EN.
module sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instr,
`ifdef SEQUENCER_SINGLE_STEP_EN
    input  logic       step_mode,
    input  logic       step,
`endif
    output logic [7:0] state,
    output logic       retire,
    output logic       halted
);

    typedef enum logic [7:0] {
        STATE_FETCH_PC   = 8'h00,
        STATE_FETCH_INST = 8'h01,
        STATE_DECODE     = 8'h02,
        STATE_ALU_EXEC   = 8'h03,
        STATE_ALU_OUT    = 8'h04,
        STATE_MOV_REG    = 8'h05,
        STATE_SET_REG    = 8'h06,
        STATE_LOAD_ADDR  = 8'h07,
        STATE_SET_MEM    = 8'h08,
        STATE_JUMP       = 8'h09,
        STATE_FETCH_SP   = 8'h0A,
        STATE_STORE_PC   = 8'h0B,
        STATE_TMP_JUMP   = 8'h0C,
        STATE_INC_SP     = 8'h0D,
        STATE_RET        = 8'h0E,
        STATE_STACK_REG  = 8'h0F,
        STATE_RIN_STORE  = 8'h10,
        STATE_ROUT_STORE = 8'h11,
        STATE_SET_MAR    = 8'h12,
        STATE_MIN_STORE  = 8'h13,
        STATE_MOUT_STORE = 8'h14,
        STATE_HALT       = 8'h15,
        STATE_WAIT       = 8'h16
    } state_t;

    state_t     r_state;
    logic       r_opfetch;
    logic [2:0] r_step;

    state_t     w_next;
    state_t     w_end;
    state_t     w_seq_next;
    logic [2:0] w_len;
    logic       w_seq_last;
    logic       w_last;
    logic       w_opfetch_nxt;
    logic       w_unused_operand2;

    assign w_unused_operand2 = &{1'b0, instr[2:0]};

    function automatic state_t pick(input logic [2:0] idx,
                                     input state_t a, input state_t b,
                                     input state_t c);
        case (idx)
            3'd1:    return a;
            3'd2:    return b;
            default: return c;
        endcase
    endfunction

    // Number of states after DECODE for each instruction
    function automatic logic [2:0] seq_len(input logic [7:0] ir);
        case (ir[7:6])
            2'b00:   return 3'd2;
            2'b01:   return 3'd1;
            2'b10: begin
                case (ir[5:3])
                    3'b000, 3'b011, 3'b110: return 3'd2;
                    default:                return 3'd3;
                endcase
            end
            default: begin
                case (ir[5:3])
                    3'b001, 3'b010, 3'b111: return 3'd1;
                    3'b011, 3'b100:         return 3'd2;
                    default:                return 3'd0;
                endcase
            end
        endcase
    endfunction

    // State at position idx (1-based) after DECODE
    function automatic state_t seq_at(input logic [7:0] ir,
                                      input logic [2:0] idx);
        case (ir[7:6])
            2'b00: return pick(idx, STATE_ALU_EXEC, STATE_ALU_OUT,
                               STATE_ALU_OUT);
            2'b01: return STATE_MOV_REG;
            2'b10: begin
                case (ir[5:3])
                    3'b000: return pick(idx, STATE_FETCH_PC,
                                        STATE_SET_REG, STATE_SET_REG);
                    3'b001: return pick(idx, STATE_FETCH_PC,
                                        STATE_LOAD_ADDR, STATE_SET_REG);
                    3'b010: return pick(idx, STATE_FETCH_PC,
                                        STATE_LOAD_ADDR, STATE_SET_MEM);
                    3'b011: return pick(idx, STATE_FETCH_PC,
                                        STATE_JUMP, STATE_JUMP);
                    3'b100: return pick(idx, STATE_FETCH_SP,
                                        STATE_STORE_PC, STATE_TMP_JUMP);
                    3'b101: return pick(idx, STATE_INC_SP,
                                        STATE_FETCH_SP, STATE_RET);
                    3'b110: return pick(idx, STATE_FETCH_SP,
                                        STATE_STACK_REG, STATE_STACK_REG);
                    default: return pick(idx, STATE_INC_SP,
                                         STATE_FETCH_SP, STATE_SET_REG);
                endcase
            end
            default: begin
                case (ir[5:3])
                    3'b001:  return STATE_RIN_STORE;
                    3'b010:  return STATE_ROUT_STORE;
                    3'b011:  return pick(idx, STATE_SET_MAR,
                                         STATE_MIN_STORE, STATE_MIN_STORE);
                    3'b100:  return pick(idx, STATE_SET_MAR,
                                         STATE_MOUT_STORE, STATE_MOUT_STORE);
                    3'b111:  return STATE_HALT;
                    default: return STATE_FETCH_PC;
                endcase
            end
        endcase
    endfunction

`ifdef SEQUENCER_SINGLE_STEP_EN
    logic r_step_prev;
    logic w_step_rise;

    assign w_step_rise = step & ~r_step_prev;
    assign w_end       = step_mode ? STATE_WAIT : STATE_FETCH_PC;

    // Previous step level for rising-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_step_prev <= 1'b0;
        else       r_step_prev <= step;
    end
`else
    assign w_end = STATE_FETCH_PC;
`endif

    assign w_len      = seq_len(instr);
    assign w_seq_last = (r_step >= w_len);
    assign w_seq_next = w_seq_last ? w_end : seq_at(instr, r_step + 3'd1);

    // Next-state selection; DECODE and later walk the step table
    always_comb begin
        w_next        = r_state;
        w_last        = 1'b0;
        w_opfetch_nxt = r_opfetch;
        case (r_state)
            STATE_FETCH_PC: begin
                if (r_opfetch) w_next = w_seq_next;
                else           w_next = STATE_FETCH_INST;
            end
            STATE_FETCH_INST: w_next = STATE_DECODE;
            STATE_HALT:       w_next = STATE_HALT;
`ifdef SEQUENCER_SINGLE_STEP_EN
            STATE_WAIT: begin
                if (w_step_rise) w_next = STATE_FETCH_PC;
            end
`endif
            default: begin
                w_next = w_seq_next;
                w_last = w_seq_last;
            end
        endcase
        if (w_next == STATE_FETCH_PC)
            w_opfetch_nxt = ~w_last && (r_state != STATE_FETCH_PC)
                            && (r_state != STATE_WAIT);
        else if (w_next == STATE_FETCH_INST)
            w_opfetch_nxt = 1'b0;
    end

    // State, operand-fetch flag and step counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= STATE_FETCH_PC;
            r_opfetch <= 1'b0;
            r_step    <= 3'd0;
        end else begin
            r_state   <= w_next;
            r_opfetch <= w_opfetch_nxt;
            r_step    <= (w_next == STATE_DECODE) ? 3'd0 : r_step + 3'd1;
        end
    end

    assign state  = r_state;
    assign retire = w_last;
    assign halted = (r_state == STATE_HALT);

endmodule
